// File: rtl/hgcal_act_deserializer_if.sv
// Bundles the beat stream, the assembled activation vector and the framing-error pulse.
// The DUT takes the slave modport; the sample producer/consumer side takes master.
interface hgcal_act_deserializer_if #(
  parameter int NUM_ACTS = 48,
  parameter int LANES    = 4,
  parameter int IN_W     = 8,
  parameter int ACT_BW   = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IN_W-1:0]      in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_ACTS*ACT_BW-1:0] out_data;
  logic                       frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/hgcal_act_deserializer.sv
// Quantizes LANES samples per beat to ACT_BW-bit codes and assembles double-buffered frames; HGCAL_DESER_FRAME_CHECK_EN adds in_last checking.
// out_valid rises the cycle after the last beat; in_ready drops only while both buffers hold unread frames.
module hgcal_act_deserializer #(
  parameter int NUM_ACTS = 48,
  parameter int LANES    = 4,
  parameter int IN_W     = 8,
  parameter int ACT_BW   = 2,
  parameter int SHIFT    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hgcal_act_deserializer_if.slave bus
);
  localparam int BEATS = NUM_ACTS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VEC_W = NUM_ACTS * ACT_BW;
  localparam logic [IN_W-1:0]  QMAX     = IN_W'((1 << ACT_BW) - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL} buf_st_e;

  buf_st_e                 st_q [2];
  buf_st_e                 st_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [VEC_W-1:0]        buf_q [2];
  logic [IN_W-1:0]         shf [LANES];
  logic [LANES*ACT_BW-1:0] q_beat;
  logic                    in_acc, out_hs, last_beat;

  assign in_acc    = bus.in_valid && (st_q[wr_ptr_q] != BUF_FULL);
  assign out_hs    = bus.out_ready && (st_q[rd_ptr_q] == BUF_FULL);
  assign last_beat = (cnt_q == LAST_CNT);

  // Per-lane shift then saturate to the largest code.
  always_comb begin
    q_beat = '0;
    for (int k = 0; k < LANES; k++) begin
      shf[k] = bus.in_data[k*IN_W +: IN_W] >> SHIFT;
      if (shf[k] > QMAX) q_beat[k*ACT_BW +: ACT_BW] = '1;
      else               q_beat[k*ACT_BW +: ACT_BW] = ACT_BW'(shf[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]  <= BUF_EMPTY;
      st_q[1]  <= BUF_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (in_acc) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int k = 0; k < LANES; k++) begin
          if (cnt_q == CNT_W'(b))
            buf_q[wr_ptr_q][(b*LANES+k)*ACT_BW +: ACT_BW] <= q_beat[k*ACT_BW +: ACT_BW];
        end
      end
    end
  end

  // A handshake and a frame completion touch different buffers, so both apply.
  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (out_hs) begin
      st_d[rd_ptr_q] = BUF_EMPTY;
      rd_ptr_d       = ~rd_ptr_q;
    end
    if (in_acc) begin
`ifdef HGCAL_DESER_FRAME_CHECK_EN
      if (bus.in_last && !last_beat) begin
        st_d[wr_ptr_q] = BUF_EMPTY;
        cnt_d          = '0;
        err_d          = 1'b1;
      end else
`endif
      if (last_beat) begin
        st_d[wr_ptr_q] = BUF_FULL;
        wr_ptr_d       = ~wr_ptr_q;
        cnt_d          = '0;
`ifdef HGCAL_DESER_FRAME_CHECK_EN
        err_d          = !bus.in_last;
`endif
      end else begin
        st_d[wr_ptr_q] = BUF_FILLING;
        cnt_d          = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.in_ready  = (st_q[wr_ptr_q] != BUF_FULL);
    bus.out_valid = (st_q[rd_ptr_q] == BUF_FULL);
    bus.out_data  = buf_q[rd_ptr_q];
  end

  assign bus.frame_err = err_q;

`ifndef HGCAL_DESER_FRAME_CHECK_EN
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif
endmodule

// File: doc/hgcal_act_deserializer.md
# hgcal_act_deserializer

Front-end stage of the HGCAL autoencoder pipeline. Accepts raw sensor samples as a narrow multi-lane stream and quantizes each sample to a 2-bit activation code. Assembles one full input vector per frame and presents it, registered, to the first-layer neuron LUTs. Double-buffered so one frame can fill while the previous frame waits for the consumer.

## Interface
Parameters:
- `NUM_ACTS`, default 48: activations per frame (input cells).
- `LANES`, default 4: samples accepted per beat; must divide `NUM_ACTS`.
- `IN_W`, default 8: raw sample width, unsigned.
- `ACT_BW`, default 2: activation code width.
- `SHIFT`, default 4: right-shift applied before saturation.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_data` in `LANES*IN_W`: lane k in bits [k*IN_W +: IN_W]; lane 0 is the lowest activation index of the beat.
- `in_last` in 1: marks the final beat of a frame.
- `out_valid` out 1: vector valid.
- `out_ready` in 1: consumer accepts the vector.
- `out_data` out `NUM_ACTS*ACT_BW`: activation i in bits [i*ACT_BW +: ACT_BW].
- `frame_err` out 1: one-cycle pulse on framing error; present only with the frame-check feature (see Configuration).

## Operation
- Quantize each lane independently: q = min(sample >> SHIFT, 2^ACT_BW - 1). Purely combinational before the buffer write.
- Frame length is BEATS = NUM_ACTS/LANES. A beat counter, 0..BEATS-1, selects the write slot; beat b writes activations b*LANES .. b*LANES+LANES-1.
- Two buffers, A and B. Each buffer is in state EMPTY, FILLING, or FULL. The write pointer selects the fill buffer; the read pointer selects the output buffer.
- When the last beat is accepted (count == BEATS-1), the fill buffer goes FULL, the write pointer toggles, and the count resets to 0.
- `out_valid` = (read buffer FULL). `out_data` is driven from registers only. On an `out_valid && out_ready` handshake, the read buffer goes EMPTY and the read pointer toggles.
- `in_ready` = (write buffer not FULL).
- Simultaneous events:
  - Output handshake on buffer X in the same cycle as the last beat completes buffer Y: both take effect. `out_valid` stays high next cycle, showing Y.
  - Both buffers FULL: `in_ready` = 0. It returns to 1 in the cycle after an output handshake.
- `in_last` is ignored when frame check is compiled out.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `frame_err` = 0, both buffers EMPTY, pointers 0, beat count 0.
- Latency: `out_valid` rises in the cycle after the last beat handshake, provided the read buffer was empty.
- Throughput: one beat per cycle sustained when `out_ready` = 1. Back-to-back frames need no bubble.
- `out_data` is stable while `out_valid && !out_ready`.
- Reset asserted mid-frame: the partial frame and both buffers are discarded immediately, and all outputs return to reset values asynchronously.

## Configuration
- `HGCAL_DESER_FRAME_CHECK_EN` defined:
  - `in_last` is checked on every accepted beat.
  - `in_last` = 1 with count != BEATS-1 (early last): pulse `frame_err`, discard the partial frame, reset count to 0, leave the buffer EMPTY.
  - Count == BEATS-1 with `in_last` = 0 (missing last): the frame is kept, and `frame_err` pulses.
- Not defined: `frame_err` is tied 0, and frames are delimited by beat count alone.

## Test plan
- Single frame, defaults:
  - Stimulus: 12 beats with lane samples 0x00, 0x1F, 0x2F, 0xFF.
  - Required: `out_valid` one cycle after the 12th beat; every activation group reads 0, 1, 2, 3; `out_ready` = 1 clears it.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 while sending 3 frames.
  - Required: frames 1 and 2 are buffered; `in_ready` drops after beat 24 is accepted; frame 3 stalls until `out_ready` pulses; output order is frame 1, then frame 2, with data unchanged while stalled.
- Streaming:
  - Stimulus: `out_ready` = 1 with 10 frames of continuous valid input.
  - Required: no `in_ready` deassertion; exactly 10 `out_valid` handshakes at 12-cycle spacing.
- Simultaneous completion and handshake:
  - Stimulus: the last beat of frame 2 is accepted in the same cycle frame 1 is consumed.
  - Required: `out_valid` stays 1 and shows frame 2 next cycle.
- Reset mid-frame:
  - Stimulus: assert `rst_n` = 0 after beat 5 of a frame, then send a full frame.
  - Required: all outputs take reset values immediately; the next output equals only the new frame.
- Frame check (macro defined):
  - Stimulus: `in_last` on beat 7.
  - Required: `frame_err` pulses once, no output is produced, and the following 12-beat frame is output correctly.
